sand_frame_scheduler: RTL and testbench
=======================================

# sand_frame_scheduler

Frame-level controller for the falling-sand engine, sitting between the VGA timing, the user brush and the cell next-state updater. Every STEP_DIVIDER frames it launches one updater pass. It owns the VRAM write port, multiplexing brush writes and updater writes. After the pass it copies the scratch RAM back into VRAM while clearing the scratch RAM, so the next pass starts from an empty RAM.

## Interface
- ACTIVE_COLUMNS, 640, cells per row
- ACTIVE_ROWS, 480, rows
- ADDR_WIDTH, $clog2(ACTIVE_COLUMNS*ACTIVE_ROWS), cell address width
- DATA_WIDTH, 2, cell state width
- STEP_DIVIDER, 2, frame ticks per simulation step (≥1)

Ports:
- clk_i  in  1  single clock, all logic rising-edge
- reset_ni  in  1  asynchronous, active-low reset
- frame_tick_i  in  1  one-cycle pulse at start of vertical blanking
- sim_ready_o  out  1  one-cycle start pulse to updater
- sim_done_i  in  1  one-cycle completion pulse from updater
- sim_vram_wr_en_i / sim_vram_wr_address_i / sim_vram_wr_data_i  in  1 / ADDR_WIDTH / DATA_WIDTH  updater VRAM write
- draw_req_i  in  1  brush write request, held until acked
- draw_address_i  in  ADDR_WIDTH  brush cell address
- draw_data_i  in  DATA_WIDTH  brush cell value
- draw_ack_o  out  1  brush write accepted this cycle
- vram_wr_en_o / vram_wr_address_o / vram_wr_data_o  out  1 / ADDR_WIDTH / DATA_WIDTH  VRAM write port
- ram_rd_address_o  out  ADDR_WIDTH  scratch RAM read address (RAM read latency 1 cycle)
- ram_rd_data_i  in  DATA_WIDTH  scratch RAM read data
- ram_wr_en_o / ram_wr_address_o / ram_wr_data_o  out  1 / ADDR_WIDTH / DATA_WIDTH  scratch RAM clear writes
- busy_o  out  1  high in any state other than IDLE
- overrun_o  out  1  sticky: a step came due while busy
- `SIM_PAUSE_EN` only: pause_i  in  1 and step_i  in  1 (see Configuration)

## Operation
- N = ACTIVE_COLUMNS*ACTIVE_ROWS.
- States:
  - IDLE: default state.
  - SIM: wait for the updater.
  - COPY: copy scratch RAM to VRAM and clear scratch RAM.
- Frame counter:
  - Width $clog2(STEP_DIVIDER)+1; increments on frame_tick_i.
  - On the tick where it equals STEP_DIVIDER-1, it wraps to 0 and the step is due.
  - Due step in IDLE: sets pending_start.
  - Due step in SIM or COPY: dropped, and overrun_o sets (cleared only by reset).
- IDLE, in priority order:
  - draw_req_i: draw_ack_o=1; VRAM written with draw_data_i at draw_address_i in the same cycle. If draw_address_i ≥ N, acked but vram_wr_en_o=0.
  - else if pending_start: sim_ready_o=1, pending_start cleared, go to SIM.
  - A pending step is thus deferred while brush requests keep coming.
- SIM:
  - VRAM write port passes sim_vram_wr_* through unchanged.
  - draw_ack_o=0.
  - sim_done_i moves to COPY; sim_vram_wr_en_i in that cycle is still forwarded.
- COPY:
  - Read counter rc runs 0..N-1, with ram_rd_address_o=rc.
  - Cycle after reading address a: vram_wr_en_o=1, vram_wr_address_o=a, vram_wr_data_o=ram_rd_data_i; same cycle ram_wr_en_o=1, ram_wr_address_o=a, ram_wr_data_o=0.
  - Leaves to IDLE in the cycle that writes address N-1; rc resets to 0.
- All write-port outputs are 0 when not driven per the above.

## Timing
- Reset values:
  - all outputs 0
  - state IDLE, frame counter 0, pending_start 0, rc 0
- Tick to sim_ready_o: 1 cycle minimum, when the step is due in IDLE with no draw_req_i.
- sim_done_i to first COPY write: 2 cycles (enter COPY, 1-cycle RAM latency).
- COPY lasts N+1 cycles. busy_o falls in the cycle after the last copy write.
- Simultaneous events:
  - frame_tick_i and sim_done_i together: the tick is counted; if due, it counts as overrun (busy).
  - frame_tick_i and draw_req_i together in IDLE: the draw is served and pending_start set; the step starts on the next free cycle.
- reset_ni low mid-COPY: immediate return to reset values. The RAM is left partially cleared; software/top does not rely on its contents.

## Configuration
- `SIM_PAUSE_EN` defined:
  - pause_i and step_i ports exist.
  - While pause_i=1, due steps neither set pending_start nor overrun_o.
  - A step_i pulse while paused sets pending_start.
  - Brush writes are unaffected.
- `SIM_PAUSE_EN` undefined: ports absent; behaviour as above with no pause.

## Test plan
- Reset, ACTIVE_COLUMNS=4, ACTIVE_ROWS=3, STEP_DIVIDER=2; two frame ticks -> sim_ready_o pulses exactly once, 1 cycle after the 2nd tick; busy_o=1.
- In SIM, sim_vram_wr_en_i=1, address 5, data 2'b01 -> vram_wr_* mirrors it. A concurrent draw_req_i gets draw_ack_o=0 until back in IDLE.
- Preload RAM cell 7=2'b10, others 0; pulse sim_done_i -> 12 VRAM writes over addresses 0..11, address 7 gets 2'b10. Each address is also written with 0 to RAM; busy_o falls 14 cycles after done.
- Draw to address 12 (≥N) in IDLE -> draw_ack_o=1, vram_wr_en_o=0; draw to address 3 with 2'b01 -> VRAM write same cycle.
- Two due steps during SIM (4 ticks) -> overrun_o=1 and stays 1, only one extra sim_ready_o after return to IDLE... none, since dropped steps are not queued.
- With `SIM_PAUSE_EN`, pause_i=1, 4 ticks -> no sim_ready_o and overrun_o=0. step_i pulse -> one sim_ready_o.

Source files
------------

// File: rtl/sand_frame_scheduler.sv
// Frame-level scheduler for the falling-sand engine: paces updater passes, muxes the VRAM
// write port between brush and updater, then copies/clears the scratch RAM. Optional: SIM_PAUSE_EN.
module sand_frame_scheduler #(
  parameter int ACTIVE_COLUMNS = 640,
  parameter int ACTIVE_ROWS    = 480,
  parameter int ADDR_WIDTH     = $clog2(ACTIVE_COLUMNS*ACTIVE_ROWS),
  parameter int DATA_WIDTH     = 2,
  parameter int STEP_DIVIDER   = 2
) (
  input  logic                  clk_i,
  input  logic                  reset_ni,
  input  logic                  frame_tick_i,
  output logic                  sim_ready_o,
  input  logic                  sim_done_i,
  input  logic                  sim_vram_wr_en_i,
  input  logic [ADDR_WIDTH-1:0] sim_vram_wr_address_i,
  input  logic [DATA_WIDTH-1:0] sim_vram_wr_data_i,
  input  logic                  draw_req_i,
  input  logic [ADDR_WIDTH-1:0] draw_address_i,
  input  logic [DATA_WIDTH-1:0] draw_data_i,
  output logic                  draw_ack_o,
  output logic                  vram_wr_en_o,
  output logic [ADDR_WIDTH-1:0] vram_wr_address_o,
  output logic [DATA_WIDTH-1:0] vram_wr_data_o,
  output logic [ADDR_WIDTH-1:0] ram_rd_address_o,
  input  logic [DATA_WIDTH-1:0] ram_rd_data_i,
  output logic                  ram_wr_en_o,
  output logic [ADDR_WIDTH-1:0] ram_wr_address_o,
  output logic [DATA_WIDTH-1:0] ram_wr_data_o,
  output logic                  busy_o,
  output logic                  overrun_o,
`ifdef SIM_PAUSE_EN
  input  logic                  pause_i,
  input  logic                  step_i,
`endif
  output logic [1:0]            dbg_state_o
);

  localparam int N    = ACTIVE_COLUMNS * ACTIVE_ROWS;
  localparam int FC_W = $clog2(STEP_DIVIDER) + 1;
  // One extra bit so the read counter can hold N on the final write-only cycle.
  localparam int RC_W = ADDR_WIDTH + 1;
  localparam logic [RC_W-1:0] N_RC = RC_W'(N);
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(STEP_DIVIDER - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_SIM, ST_COPY} state_e;

  state_e          state_q, state_d;
  logic [FC_W-1:0] fc_q, fc_d;
  logic            pending_q, pending_d;
  logic            overrun_q, overrun_d;
  logic [RC_W-1:0] rc_q, rc_d;
  logic [RC_W-1:0] wr_idx;
  logic            step_due;
  logic            paused;
  logic            step_req;

  assign step_due    = frame_tick_i && (fc_q == FC_LAST);
  assign busy_o      = (state_q != ST_IDLE);
  assign overrun_o   = overrun_q;
  assign dbg_state_o = state_q;
  assign wr_idx      = rc_q - RC_W'(1);

`ifdef SIM_PAUSE_EN
  assign paused   = pause_i;
  assign step_req = pause_i && step_i;
`else
  assign paused   = 1'b0;
  assign step_req = 1'b0;
`endif

  always_comb begin
    fc_d = fc_q;
    if (frame_tick_i) begin
      fc_d = (fc_q == FC_LAST) ? '0 : fc_q + FC_W'(1);
    end
  end

  always_comb begin
    state_d           = state_q;
    pending_d         = pending_q;
    overrun_d         = overrun_q;
    rc_d              = rc_q;
    sim_ready_o       = 1'b0;
    draw_ack_o        = 1'b0;
    vram_wr_en_o      = 1'b0;
    vram_wr_address_o = '0;
    vram_wr_data_o    = '0;
    ram_rd_address_o  = '0;
    ram_wr_en_o       = 1'b0;
    ram_wr_address_o  = '0;
    ram_wr_data_o     = '0;

    case (state_q)
      ST_IDLE: begin
        if (draw_req_i) begin
          draw_ack_o = 1'b1;
          if (RC_W'(draw_address_i) < N_RC) begin
            vram_wr_en_o      = 1'b1;
            vram_wr_address_o = draw_address_i;
            vram_wr_data_o    = draw_data_i;
          end
        end else if (pending_q) begin
          sim_ready_o = 1'b1;
          pending_d   = 1'b0;
          state_d     = ST_SIM;
        end
      end
      ST_SIM: begin
        vram_wr_en_o      = sim_vram_wr_en_i;
        vram_wr_address_o = sim_vram_wr_address_i;
        vram_wr_data_o    = sim_vram_wr_data_i;
        if (sim_done_i) begin
          state_d = ST_COPY;
          rc_d    = '0;
        end
      end
      ST_COPY: begin
        if (rc_q < N_RC) begin
          ram_rd_address_o = rc_q[ADDR_WIDTH-1:0];
        end
        // Data for the address read last cycle arrives now: forward to VRAM, clear in RAM.
        if (rc_q != '0) begin
          vram_wr_en_o      = 1'b1;
          vram_wr_address_o = wr_idx[ADDR_WIDTH-1:0];
          vram_wr_data_o    = ram_rd_data_i;
          ram_wr_en_o       = 1'b1;
          ram_wr_address_o  = wr_idx[ADDR_WIDTH-1:0];
        end
        if (rc_q == N_RC) begin
          state_d = ST_IDLE;
          rc_d    = '0;
        end else begin
          rc_d = rc_q + RC_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Evaluated after the launch so a step falling due in the launch cycle is not lost.
    if (step_due && !paused) begin
      if (state_q == ST_IDLE) pending_d = 1'b1;
      else                    overrun_d = 1'b1;
    end
    if (step_req) pending_d = 1'b1;
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q   <= ST_IDLE;
      fc_q      <= '0;
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
      rc_q      <= '0;
    end else begin
      state_q   <= state_d;
      fc_q      <= fc_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
      rc_q      <= rc_d;
    end
  end

endmodule

// File: tb/tb_sand_frame_scheduler.sv
// Directed-plus-random bench for sand_frame_scheduler on a 4x3 grid with STEP_DIVIDER=2.
module tb_sand_frame_scheduler;
  localparam int COLS = 4;
  localparam int ROWS = 3;
  localparam int N    = COLS * ROWS;
  localparam int AW   = $clog2(N);
  localparam int DW   = 2;
  localparam int DIV  = 2;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          frame_tick, sim_ready, sim_done;
  logic          sim_en;
  logic [AW-1:0] sim_addr;
  logic [DW-1:0] sim_data;
  logic          draw_req, draw_ack;
  logic [AW-1:0] draw_addr;
  logic [DW-1:0] draw_data;
  logic          vram_en;
  logic [AW-1:0] vram_addr;
  logic [DW-1:0] vram_data;
  logic [AW-1:0] ram_rd_addr;
  logic [DW-1:0] ram_rd_data;
  logic          ram_en;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_data;
  logic          busy, overrun;
  logic [1:0]    dbg_state;
  logic          pause, step;

  int total = 0;
  int bad   = 0;
  int ticks = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] preload [16];
  logic [DW-1:0] exp_d;
  logic [AW-1:0] a_r;
  logic [DW-1:0] d_r;

  // Scratch RAM (1-cycle read latency) and a VRAM image collected from the write port.
  logic [DW-1:0] ram_mem  [16];
  logic [DW-1:0] vram_mem [16];
  logic          pre_en;
  logic [3:0]    pre_addr;
  logic [DW-1:0] pre_data;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    ram_rd_data <= ram_mem[ram_rd_addr];
    if (ram_en) ram_mem[ram_addr] <= ram_data;
    else if (pre_en) ram_mem[pre_addr] <= pre_data;
  end

  always @(posedge clk) begin
    if (vram_en) vram_mem[vram_addr] <= vram_data;
  end

  sand_frame_scheduler #(
    .ACTIVE_COLUMNS(COLS), .ACTIVE_ROWS(ROWS), .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW), .STEP_DIVIDER(DIV)
  ) dut (
    .clk_i(clk), .reset_ni(reset_n), .frame_tick_i(frame_tick),
    .sim_ready_o(sim_ready), .sim_done_i(sim_done),
    .sim_vram_wr_en_i(sim_en), .sim_vram_wr_address_i(sim_addr), .sim_vram_wr_data_i(sim_data),
    .draw_req_i(draw_req), .draw_address_i(draw_addr), .draw_data_i(draw_data), .draw_ack_o(draw_ack),
    .vram_wr_en_o(vram_en), .vram_wr_address_o(vram_addr), .vram_wr_data_o(vram_data),
    .ram_rd_address_o(ram_rd_addr), .ram_rd_data_i(ram_rd_data),
    .ram_wr_en_o(ram_en), .ram_wr_address_o(ram_addr), .ram_wr_data_o(ram_data),
    .busy_o(busy), .overrun_o(overrun),
`ifdef SIM_PAUSE_EN
    .pause_i(pause), .step_i(step),
`endif
    .dbg_state_o(dbg_state)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One frame tick lasting one cycle; leaves the bench at the start of the following cycle.
  task automatic pulse_tick();
    frame_tick = 1'b1;
    cyc();
    frame_tick = 1'b0;
    ticks++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; frame_tick = 0; sim_done = 0; sim_en = 0; sim_addr = '0; sim_data = '0;
    draw_req = 0; draw_addr = '0; draw_data = '0; pre_en = 0; pre_addr = '0; pre_data = '0;
    pause = 0; step = 0;
    repeat (3) cyc();
    check("rst_ready", sim_ready, 0);
    check("rst_ack", draw_ack, 0);
    check("rst_vram_en", vram_en, 0);
    check("rst_ram_en", ram_en, 0);
    check("rst_rd_addr", ram_rd_addr, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    reset_n = 1'b1;
    cyc();

    // Brush writes in IDLE: out-of-range addresses are acked but not written.
    for (int i = 0; i < 10; i++) begin
      a_r = (i == 0) ? AW'(12) : (i == 1) ? AW'(3) : AW'($urandom_range(0, 15));
      d_r = (i == 1) ? DW'(1) : DW'($urandom_range(0, 3));
      draw_req = 1'b1; draw_addr = a_r; draw_data = d_r;
      #1;
      check("draw_ack", draw_ack, 1);
      check("draw_vram_en", vram_en, (int'(a_r) < N) ? 1 : 0);
      if (int'(a_r) < N) begin
        check("draw_vram_addr", vram_addr, a_r);
        check("draw_vram_data", vram_data, d_r);
      end
      check("draw_ready", sim_ready, 0);
      cyc();
    end
    draw_req = 1'b0;

    // Preload the scratch RAM with random cells, cell 7 fixed at 2'b10.
    for (int a = 0; a < 16; a++) begin
      preload[a] = (a == 7) ? DW'(2) : DW'($urandom_range(0, 3));
      pre_en = 1'b1; pre_addr = 4'(a); pre_data = preload[a];
      cyc();
    end
    pre_en = 1'b0;

    // Two ticks: the second is due, sim_ready follows one cycle later, exactly once.
    pulse_tick();
    #1 check("tick1_ready", sim_ready, (ticks % DIV == 0) ? 1 : 0);
    cyc();
    pulse_tick();
    #1 check("tick2_ready", sim_ready, (ticks % DIV == 0) ? 1 : 0);
    check("tick2_busy", busy, 0);
    cyc();
    check("sim_ready_once", sim_ready, 0);
    check("sim_busy", busy, 1);

    // SIM: updater writes pass through, brush held off.
    draw_req = 1'b1; draw_addr = AW'(3); draw_data = DW'(1);
    for (int i = 0; i < 8; i++) begin
      sim_en   = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      sim_addr = (i == 0) ? AW'(5) : AW'($urandom_range(0, N - 1));
      sim_data = (i == 0) ? DW'(1) : DW'($urandom_range(0, 3));
      #1;
      check("sim_ack", draw_ack, 0);
      check("sim_vram_en", vram_en, sim_en);
      if (sim_en) begin
        check("sim_vram_addr", vram_addr, sim_addr);
        check("sim_vram_data", vram_data, sim_data);
      end
      check("sim_ram_en", ram_en, 0);
      cyc();
    end

    // Done cycle still forwards the updater write.
    sim_done = 1'b1; sim_en = 1'b1; sim_addr = AW'($urandom_range(0, N - 1)); sim_data = DW'($urandom_range(0, 3));
    #1;
    check("done_vram_en", vram_en, 1);
    check("done_vram_addr", vram_addr, sim_addr);
    check("done_vram_data", vram_data, sim_data);
    cyc();
    sim_done = 1'b0; sim_en = 1'b0;
    for (int a = 0; a < N; a++) exp_q.push_back(preload[a]);
    #1;
    check("copy0_vram_en", vram_en, 0);
    check("copy0_ram_en", ram_en, 0);
    check("copy0_rd_addr", ram_rd_addr, 0);
    check("copy0_ack", draw_ack, 0);
    cyc();
    for (int a = 0; a < N; a++) begin
      exp_d = exp_q.pop_front();
      check("copy_vram_en", vram_en, 1);
      check("copy_vram_addr", vram_addr, a);
      check("copy_vram_data", vram_data, exp_d);
      check("copy_ram_en", ram_en, 1);
      check("copy_ram_addr", ram_addr, a);
      check("copy_ram_data", ram_data, 0);
      check("copy_ack", draw_ack, 0);
      check("copy_busy", busy, 1);
      if (a < N - 1) check("copy_rd_addr", ram_rd_addr, a + 1);
      cyc();
    end
    // 14 cycles after done: back in IDLE, held brush request served at once.
    check("post_busy", busy, 0);
    check("post_ack", draw_ack, 1);
    check("post_vram_en", vram_en, 1);
    check("post_vram_addr", vram_addr, 3);
    check("post_vram_data", vram_data, 1);
    cyc();
    draw_req = 1'b0;
    for (int a = 0; a < N; a++) begin
      check("ram_cleared", ram_mem[a], 0);
      check("vram_image", vram_mem[a], (a == 3) ? 1 : preload[a]);
    end

    // Overrun: a due step in SIM (with sim_done) and another in COPY are dropped.
    pulse_tick();
    #1 check("t3_ready", sim_ready, (ticks % DIV == 0) ? 1 : 0);
    cyc();
    pulse_tick();
    #1 check("t4_ready", sim_ready, (ticks % DIV == 0) ? 1 : 0);
    cyc();
    pulse_tick();
    #1 check("t5_overrun", overrun, 0);
    cyc();
    frame_tick = 1'b1; sim_done = 1'b1;
    cyc();
    frame_tick = 1'b0; sim_done = 1'b0; ticks++;
    check("t6_overrun", overrun, (ticks % DIV == 0) ? 1 : 0);
    check("t6_busy", busy, 1);
    cyc();
    for (int k = 2; k <= N + 1; k++) begin
      frame_tick = (k == 4 || k == 7);
      #1 check("ovr_copy_busy", busy, 1);
      cyc();
      if (frame_tick) ticks++;
      frame_tick = 1'b0;
    end
    check("ovr_post_busy", busy, 0);
    check("ovr_post_overrun", overrun, 1);
    for (int i = 0; i < 4; i++) begin
      check("ovr_no_restart", sim_ready, 0);
      cyc();
    end
    check("ovr_sticky", overrun, 1);

    // Tick together with a brush request: draw first, start deferred.
    pulse_tick();
    #1 check("t9_ready", sim_ready, 0);
    cyc();
    draw_req = 1'b1; draw_addr = AW'($urandom_range(0, N - 1)); draw_data = DW'($urandom_range(0, 3));
    frame_tick = 1'b1;
    #1 check("tdraw_ack", draw_ack, 1);
    check("tdraw_ready", sim_ready, 0);
    cyc();
    frame_tick = 1'b0; ticks++;
    draw_addr = AW'($urandom_range(0, N - 1));
    #1 check("defer_ack", draw_ack, 1);
    check("defer_ready", sim_ready, 0);
    cyc();
    draw_req = 1'b0;
    #1 check("defer_start", sim_ready, (ticks % DIV == 0) ? 1 : 0);
    cyc();
    check("defer_busy", busy, 1);

    // Reset in the middle of COPY returns to reset values immediately.
    sim_done = 1'b1;
    cyc();
    sim_done = 1'b0;
    repeat (4) cyc();
    check("midcopy_ram_en", ram_en, 1);
    reset_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_vram_en", vram_en, 0);
    check("arst_ram_en", ram_en, 0);
    check("arst_rd_addr", ram_rd_addr, 0);
    check("arst_overrun", overrun, 0);
    cyc();
    reset_n = 1'b1;
    ticks = 0;
    cyc();

`ifdef SIM_PAUSE_EN
    pause = 1'b1;
    for (int i = 0; i < 4; i++) begin
      pulse_tick();
      #1 check("pause_ready", sim_ready, 0);
      check("pause_overrun", overrun, 0);
      cyc();
    end
    step = 1'b1;
    cyc();
    step = 1'b0;
    #1 check("step_ready", sim_ready, 1);
    cyc();
    check("step_busy", busy, 1);
    pause = 1'b0;
`else
    pulse_tick();
    #1 check("rst_t1_ready", sim_ready, (ticks % DIV == 0) ? 1 : 0);
    cyc();
    pulse_tick();
    #1 check("rst_t2_ready", sim_ready, (ticks % DIV == 0) ? 1 : 0);
    cyc();
    check("rst_t2_busy", busy, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
